// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//
// Synchronises, debounces and edge-detects the board push-buttons so that the
// game logic sees exactly one event per physical press, plus an optional
// auto-repeat pulse train while a button is held.
//
// Parameters:
//   N_BTN       number of buttons (bit 0=C, 1=U, 2=D, 3=L, 4=R)
//   DEB_CYCLES  stable cycles needed to accept a press or a release (>=2)
//   REP_DELAY   held cycles before the first repeat pulse (>=2)
//   REP_PERIOD  cycles between subsequent repeat pulses (>=2)
//   CNT_W       per-button counter width, holds max(...)-1 of the above
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   btn_raw    in   raw pin levels, asynchronous to clk, active high
//   rep_en     in   per-button auto-repeat enable, synchronous
//   btn_level  out  debounced level, registered
//   btn_pulse  out  one-cycle pulse on accepted press and each repeat, registered
//   btn_any    out  OR of btn_pulse
// ---------------------------------------------------------------------------
module btn_conditioner #(
    parameter int unsigned N_BTN      = 5,
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned REP_DELAY  = 50_000_000,
    parameter int unsigned REP_PERIOD = 10_000_000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] rep_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             btn_any
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REP_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_HELD,
        ST_REPEAT,
        ST_RELEASE
    } state_t;

    // Two-flop synchroniser; sync2_q is the level every FSM works from.
    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level_q;
        logic             pulse_q;
        logic             s;

        assign s = sync2_q[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                // Pulse is a one-cycle strobe unless a branch below re-arms it.
                pulse_q <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (s) begin
                            state_q <= ST_ARM;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    ST_ARM: begin
                        if (!s) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_q <= ST_HELD;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    ST_HELD: begin
                        if (!s) begin
                            state_q <= ST_RELEASE;
                            cnt_q   <= CNT_ONE;
                        end else if (rep_en[i] && (cnt_q == RD_LAST)) begin
                            state_q <= ST_REPEAT;
                            cnt_q   <= '0;
                            pulse_q <= 1'b1;
                        end else if (cnt_q != RD_LAST) begin
                            // Saturate so a late rep_en fires immediately.
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    ST_REPEAT: begin
                        if (!s) begin
                            state_q <= ST_RELEASE;
                            cnt_q   <= CNT_ONE;
                        end else if (rep_en[i] && (cnt_q == RP_LAST)) begin
                            cnt_q   <= '0;
                            pulse_q <= 1'b1;
                        end else if (cnt_q != RP_LAST) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    ST_RELEASE: begin
                        // A bounce back high returns to HELD silently: no pulse.
                        if (s) begin
                            state_q <= ST_HELD;
                            cnt_q   <= '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        assign btn_level[i] = level_q;
        assign btn_pulse[i] = pulse_q;
    end

    assign btn_any = |btn_pulse;

endmodule

// File: tb/tb_btn_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_conditioner
//
// Directed bench for btn_conditioner with short debounce/repeat settings.
// Each scenario queues one raw-input vector and one expected output set per
// clock edge; the run loop drives a vector, waits for the edge, then pops and
// compares the expected pulse/level/any values. Expected values come from the
// press/release/repeat timing rules, edge 0 being the first edge that samples
// a change.
// ---------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int unsigned NB  = 5;
    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 10;
    localparam int unsigned RP  = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] rep_en;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_pulse;
    logic          btn_any;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN      (NB),
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RD),
        .REP_PERIOD (RP),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .rep_en    (rep_en),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .btn_any   (btn_any)
    );

    typedef struct packed {
        logic [NB-1:0] pulse;
        logic [NB-1:0] level;
    } exp_t;

    exp_t          exp_q[$];
    logic [NB-1:0] stim_q[$];
    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;

    task automatic push_edge(input logic [NB-1:0] raw,
                             input logic [NB-1:0] pulse,
                             input logic [NB-1:0] level);
        exp_t e;
        e.pulse = pulse;
        e.level = level;
        stim_q.push_back(raw);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input int k, input exp_t e);
        logic exp_any;
        exp_any = |e.pulse;
        n_vec++;
        assert (btn_pulse === e.pulse) else begin
            n_err++;
            $error("FAIL %s pulse @edge %0d: got %b want %b", tag, k, btn_pulse, e.pulse);
        end
        n_vec++;
        assert (btn_level === e.level) else begin
            n_err++;
            $error("FAIL %s level @edge %0d: got %b want %b", tag, k, btn_level, e.level);
        end
        n_vec++;
        assert (btn_any === exp_any) else begin
            n_err++;
            $error("FAIL %s any @edge %0d: got %b want %b", tag, k, btn_any, exp_any);
        end
    endtask

    // Must be entered 1 time unit after a rising edge.
    task automatic run(input string tag);
        exp_t e;
        int   k;
        k = 0;
        while (stim_q.size() > 0) begin
            btn_raw = stim_q.pop_front();
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL %s scoreboard empty @edge %0d: got none want entry", tag, k);
            end else begin
                e = exp_q.pop_front();
                check(tag, k, e);
            end
            k++;
        end
    endtask

    initial begin
        exp_t z;
        z.pulse = '0;
        z.level = '0;

        rst_n   = 1'b0;
        btn_raw = '0;
        rep_en  = '0;
        #2;
        check("reset", -1, z);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean press on U, no repeat: one pulse, level until 5 edges after release.
        for (int k = 0; k < 40; k++)
            push_edge((k < 30) ? 5'b00010 : 5'b00000,
                      (k == 5) ? 5'b00010 : 5'b00000,
                      (k >= 5 && k < 35) ? 5'b00010 : 5'b00000);
        run("press");

        // Bouncing D: toggles every 2 cycles, last rise at edge 20.
        for (int k = 0; k < 42; k++) begin
            logic hi;
            hi = (k < 20) ? (((k / 2) % 2) == 0) : (k < 30);
            push_edge(hi ? 5'b00100 : 5'b00000,
                      (k == 25) ? 5'b00100 : 5'b00000,
                      (k >= 25 && k < 35) ? 5'b00100 : 5'b00000);
        end
        run("bounce");

        // Auto-repeat on L held 32 cycles.
        rep_en = 5'b01000;
        for (int k = 0; k < 44; k++)
            push_edge((k < 32) ? 5'b01000 : 5'b00000,
                      (k == 5 || k == 15 || k == 20 || k == 25 || k == 30) ? 5'b01000 : 5'b00000,
                      (k >= 5 && k < 37) ? 5'b01000 : 5'b00000);
        run("repeat");
        rep_en = '0;

        // Two-cycle release glitch on R while held.
        for (int k = 0; k < 36; k++)
            push_edge(((k < 10) || (k >= 12 && k < 25)) ? 5'b10000 : 5'b00000,
                      (k == 5) ? 5'b10000 : 5'b00000,
                      (k >= 5 && k < 30) ? 5'b10000 : 5'b00000);
        run("glitch");

        // C and R pressed together.
        for (int k = 0; k < 20; k++)
            push_edge((k < 10) ? 5'b10001 : 5'b00000,
                      (k == 5) ? 5'b10001 : 5'b00000,
                      (k >= 5 && k < 15) ? 5'b10001 : 5'b00000);
        run("simul");

        // Reset 3 cycles into a press (FSM in ARM).
        for (int k = 0; k < 3; k++)
            push_edge(5'b00010, 5'b00000, 5'b00000);
        run("arm");
        rst_n = 1'b0;
        #1;
        check("rst_arm", -1, z);
        @(posedge clk);
        #1;
        check("rst_arm_hold", -1, z);
        rst_n = 1'b1;

        // Button still held: treated as a new press from the first post-reset edge.
        for (int k = 0; k < 8; k++)
            push_edge(5'b00010,
                      (k == 5) ? 5'b00010 : 5'b00000,
                      (k >= 5) ? 5'b00010 : 5'b00000);
        run("post_rst");

        // Reset while level is high clears outputs without waiting for an edge.
        rst_n = 1'b0;
        #1;
        check("rst_held", -1, z);
        btn_raw = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++)
            push_edge(5'b00000, 5'b00000, 5'b00000);
        run("idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Synchronises, debounces and edge-detects the five Nexys4 push-buttons (BtnC/U/D/L/R) before they reach the game logic. It sits between the board pins and `block_controller`. It gives each button three things: a clean level, a single-cycle press pulse, and an optional auto-repeat pulse train while the button is held. It runs on the 100 MHz ClkPort domain so that every downstream consumer sees one well-defined event per physical press.

## Interface
- `N_BTN`, default 5: number of buttons. Bit map: 0=C, 1=U, 2=D, 3=L, 4=R.
- `DEB_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a press or a release (10 ms). Must be ≥2.
- `REP_DELAY`, default 50_000_000: held cycles before the first repeat pulse (500 ms). Must be ≥2.
- `REP_PERIOD`, default 10_000_000: cycles between subsequent repeat pulses (100 ms). Must be ≥2.
- `CNT_W`, default 26: per-button counter width. Must hold max(DEB_CYCLES, REP_DELAY, REP_PERIOD)−1.
- `clk`, in, 1: system clock, ClkPort.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `btn_raw`, in, N_BTN: raw pin levels, asynchronous to `clk`. Active high.
- `rep_en`, in, N_BTN: per-button auto-repeat enable, synchronous.
- `btn_level`, out, N_BTN: debounced level, registered.
- `btn_pulse`, out, N_BTN: one-cycle pulse on accepted press and on each repeat, registered.
- `btn_any`, out, 1: combinational OR of `btn_pulse`.

## Operation
- **Synchroniser:** each bit of `btn_raw` passes through 2 flip-flops (reset 0), giving the synchronised level `s`.
- **Per-button FSM:** states IDLE, ARM, HELD, REPEAT, RELEASE. Each button has its own `CNT_W` counter.
- **IDLE** (`level`=0):
  - `s`=1 → ARM, cnt=1.
- **ARM** (`level`=0):
  - `s`=0 → IDLE, no pulse.
  - `s`=1 and cnt==DEB_CYCLES−1 → HELD, cnt=0, `level`←1, `pulse`←1.
  - Otherwise `s`=1 → cnt++.
- **HELD** (`level`=1):
  - `s`=0 → RELEASE, cnt=1.
  - `rep_en`=1 and cnt==REP_DELAY−1 → REPEAT, cnt=0, `pulse`←1.
  - Otherwise cnt++, saturating at REP_DELAY−1.
- **REPEAT** (`level`=1):
  - `s`=0 → RELEASE, cnt=1.
  - `rep_en`=1 and cnt==REP_PERIOD−1 → stay, cnt=0, `pulse`←1.
  - Otherwise cnt++, saturating at REP_PERIOD−1.
  - `rep_en`=0 suppresses pulses; the FSM stays in REPEAT.
- **RELEASE** (`level`=1):
  - `s`=1 → HELD, cnt=0. A release bounce never generates a pulse.
  - `s`=0 and cnt==DEB_CYCLES−1 → IDLE, `level`←0.
  - Otherwise cnt++.
- **Pulse rules:**
  - `btn_pulse[i]` is high for exactly one cycle per event and is cleared the following cycle.
  - A pulse is never produced on release.
- **Independence:** buttons are fully independent. Simultaneous presses yield simultaneous pulses.
- **Reset:** `rst_n`=0 asynchronously forces every FSM to IDLE, clears counters and synchronisers, and drives `btn_level`=0, `btn_pulse`=0, `btn_any`=0.
  - A button still held when reset deasserts is handled as a new press.

## Timing
- **Press latency:** `btn_raw` is stable high, and edge E0 is the first to sample it. The pulse and the `level` rise are registered at edge E0+DEB_CYCLES+1.
- **Release latency:** same rule. `level` falls at E0+DEB_CYCLES+1 after the first edge that samples low.
- **First repeat:** REP_DELAY edges after the press pulse.
- **Subsequent repeats:** every REP_PERIOD edges.
- **Dropped presses:** a press shorter than DEB_CYCLES synchronised cycles is dropped.
- **Throughput:** at most one pulse per button per cycle.
- **No back-pressure:** consumers must sample `btn_pulse` every `clk` cycle.

## Test plan
Sim parameters: DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=5. Edge 0 = first edge sampling the change.
- **Clean press:** `btn_raw[1]`=1 for 30 cycles, `rep_en`=0.
  - Single pulse on bit 1 at edge 5, and `btn_any` high for that cycle.
  - `level[1]`=1 from edge 5 until 5 edges after release; no pulse on release.
- **Bounce:** `btn_raw[2]` toggles every 2 cycles for 20 cycles, then stays 1.
  - No pulse and `level`=0 during the toggling.
  - Exactly one pulse 5 edges after the last rise.
- **Auto-repeat:** `rep_en[3]`=1, `btn_raw[3]` held for 32 cycles.
  - Pulses at edges 5, 15, 20, 25, 30.
  - Release → `level` falls 5 edges later with no further pulses.
- **Release glitch:** while bit 4 is held, `btn_raw[4]`=0 for 2 cycles.
  - `level[4]` stays 1, and no new pulse is produced.
- **Simultaneous presses:** `btn_raw[0]` and `btn_raw[4]` rise on the same cycle.
  - Both pulses at edge 5 in the same cycle; `btn_any` is a single-cycle high.
- **Mid-ARM reset:** `rst_n` pulsed low 3 cycles after a press.
  - All outputs are 0 immediately and no pulse is produced.
  - With the button still held, a pulse occurs 5 edges after the first post-reset edge.
